dot_engine_arbiter: RTL and testbench

- Shares one serial fixed-point dot engine (fixed_point_slow_dot) among NUM_REQ requesters.
- Grants requesters round-robin and latches the granted operand vectors.
- Pulses the engine start, holds the operands stable for the whole computation, and returns the result tagged with the requester ID over one shared response channel.
- Includes a watchdog that turns a hung engine into an error response.

---
 rtl/dot_arb_pkg.sv | 23 ++
 rtl/dot_engine_arbiter_rr_arbiter.sv | 40 ++++
 rtl/dot_engine_arbiter.sv | 152 +++++++++++++++
 tb/tb_dot_engine_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dot_arb_pkg.sv
// Shared types and width helpers for the dot-engine arbiter.
package dot_arb_pkg;

   // Job sequencing states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } arb_state_e;

   // Result width of the fixed-point dot engine
   function automatic int p_width(input int aw, input int af, input int bw,
                                  input int bf, input int pf);
      return aw + bw - (af + bf - pf);
   endfunction

   // Width of a requester index (at least one bit)
   function automatic int id_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/dot_engine_arbiter_rr_arbiter.sv
// Combinational round-robin grant: first asserted request after ptr_i, with wrap.
module rr_arbiter
   import dot_arb_pkg::*;
#(
   parameter  int NUM_REQ = 3,
   localparam int ID_W    = id_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [ID_W-1:0]    ptr_i,
   output logic [NUM_REQ-1:0] grant_o,
   output logic [ID_W-1:0]    idx_o,
   output logic               valid_o
);

   logic [ID_W:0]   sum_w;
   logic [ID_W-1:0] cand_w;

   // Scan farthest candidate first so the one nearest ptr_i+1 overwrites the rest
   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      sum_w   = '0;
      cand_w  = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         sum_w = {1'b0, ptr_i} + (ID_W+1)'(k);
         if (sum_w >= (ID_W+1)'(NUM_REQ)) begin
            sum_w = sum_w - (ID_W+1)'(NUM_REQ);
         end
         cand_w = sum_w[ID_W-1:0];
         if (req_i[cand_w]) begin
            grant_o         = '0;
            grant_o[cand_w] = 1'b1;
            idx_o           = cand_w;
            valid_o         = 1'b1;
         end
      end
   end

endmodule

// File: rtl/dot_engine_arbiter.sv
// Shares one serial dot engine among NUM_REQ requesters with a watchdog.
module dot_engine_arbiter
   import dot_arb_pkg::*;
#(
   parameter  int NUM_REQ     = 3,
   parameter  int N           = 3,
   parameter  int A_WIDTH     = 16,
   parameter  int A_FRAC_BITS = 14,
   parameter  int B_WIDTH     = 16,
   parameter  int B_FRAC_BITS = 14,
   parameter  int P_FRAC_BITS = 14,
   parameter  int TIMEOUT     = 16,
   localparam int P_WIDTH     = p_width(A_WIDTH, A_FRAC_BITS, B_WIDTH, B_FRAC_BITS, P_FRAC_BITS),
   localparam int ID_W        = id_width(NUM_REQ)
) (
   input  logic                           clk_in,
   input  logic                           rst_in,
   input  logic [NUM_REQ-1:0]             req_valid,
   output logic [NUM_REQ-1:0]             req_ready,
   input  logic [NUM_REQ*N*A_WIDTH-1:0]   req_A,
   input  logic [NUM_REQ*N*B_WIDTH-1:0]   req_B,
   output logic                           resp_valid,
   input  logic                           resp_ready,
   output logic [ID_W-1:0]                resp_id,
   output logic [P_WIDTH-1:0]             resp_P,
   output logic                           resp_err,
   output logic [N*A_WIDTH-1:0]           eng_A,
   output logic [N*B_WIDTH-1:0]           eng_B,
   output logic                           eng_valid_in,
   input  logic                           eng_valid_out,
   input  logic [P_WIDTH-1:0]             eng_P,
   output logic                           busy
);

   localparam int VA_W = N * A_WIDTH;
   localparam int VB_W = N * B_WIDTH;
   localparam int WD_W = $clog2(TIMEOUT);

   arb_state_e          state_q, state_d;
   logic [ID_W-1:0]     ptr_q, ptr_d;
   logic [ID_W-1:0]     id_q, id_d;
   logic [VA_W-1:0]     a_q, a_d;
   logic [VB_W-1:0]     b_q, b_d;
   logic [WD_W-1:0]     wd_q, wd_d;
   logic [P_WIDTH-1:0]  p_q, p_d;
   logic                err_q, err_d;

   logic [NUM_REQ-1:0]  grant;
   logic [ID_W-1:0]     grant_idx;
   logic                grant_valid;

   logic [VA_W-1:0]     req_a_arr [NUM_REQ];
   logic [VB_W-1:0]     req_b_arr [NUM_REQ];

   // Split the flat request buses into per-requester operand vectors
   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_split
      assign req_a_arr[gi] = req_A[gi*VA_W +: VA_W];
      assign req_b_arr[gi] = req_B[gi*VB_W +: VB_W];
   end

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_rr (
      .req_i   (req_valid),
      .ptr_i   (ptr_q),
      .grant_o (grant),
      .idx_o   (grant_idx),
      .valid_o (grant_valid)
   );

   // Accept is offered only while idle and never during reset
   assign req_ready    = (state_q == IDLE && !rst_in) ? grant : '0;
   assign eng_valid_in = (state_q == ISSUE);
   assign resp_valid   = (state_q == RESP);
   assign busy         = (state_q != IDLE);
   assign eng_A        = a_q;
   assign eng_B        = b_q;
   assign resp_id      = id_q;
   assign resp_P       = p_q;
   assign resp_err     = err_q;

   // State and datapath registers; reset drops any in-flight job
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q <= IDLE;
         ptr_q   <= ID_W'(NUM_REQ-1);
         id_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         wd_q    <= '0;
         p_q     <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         id_q    <= id_d;
         a_q     <= a_d;
         b_q     <= b_d;
         wd_q    <= wd_d;
         p_q     <= p_d;
         err_q   <= err_d;
      end
   end

   // Next-state logic: grant, start pulse, wait with watchdog, hold response
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      id_d    = id_q;
      a_d     = a_q;
      b_d     = b_q;
      wd_d    = wd_q;
      p_d     = p_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (grant_valid && !rst_in) begin
               a_d     = req_a_arr[grant_idx];
               b_d     = req_b_arr[grant_idx];
               id_d    = grant_idx;
               ptr_d   = grant_idx;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            wd_d    = '0;
            state_d = WAIT;
         end
         WAIT: begin
            // A done pulse on the last watchdog cycle still counts as success
            if (eng_valid_out) begin
               p_d     = eng_P;
               err_d   = 1'b0;
               state_d = RESP;
            end else if (wd_q == WD_W'(TIMEOUT-1)) begin
               p_d     = '0;
               err_d   = 1'b1;
               state_d = RESP;
            end else begin
               wd_d = wd_q + 1'b1;
            end
         end
         RESP: begin
            if (resp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_dot_engine_arbiter.sv
// Directed bench for dot_engine_arbiter with a small behavioural engine.
module tb_dot_engine_arbiter;

   localparam int NR  = 3;
   localparam int N   = 3;
   localparam int LAT = 4;

   logic          clk_in = 1'b0;
   logic          rst_in = 1'b1;
   logic [NR-1:0] req_valid = '0;
   logic [NR-1:0] req_ready;
   logic [NR*N*16-1:0] req_A = '0;
   logic [NR*N*16-1:0] req_B = '0;
   logic          resp_valid;
   logic          resp_ready = 1'b0;
   logic [1:0]    resp_id;
   logic [17:0]   resp_P;
   logic          resp_err;
   logic [N*16-1:0] eng_A;
   logic [N*16-1:0] eng_B;
   logic          eng_valid_in;
   logic          eng_valid_out;
   logic [17:0]   eng_P;
   logic          busy;

   int errors = 0;
   int checks = 0;

   always #5 clk_in = ~clk_in;

   dot_engine_arbiter dut (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_A         (req_A),
      .req_B         (req_B),
      .resp_valid    (resp_valid),
      .resp_ready    (resp_ready),
      .resp_id       (resp_id),
      .resp_P        (resp_P),
      .resp_err      (resp_err),
      .eng_A         (eng_A),
      .eng_B         (eng_B),
      .eng_valid_in  (eng_valid_in),
      .eng_valid_out (eng_valid_out),
      .eng_P         (eng_P),
      .busy          (busy)
   );

   // Behavioural engine: fixed latency, Q2.14 x Q2.14 -> Q.14, truncated to 18 bits
   logic          eng_hang = 1'b0;
   logic          stray = 1'b0;
   logic          m_active;
   int            m_cnt;
   logic [47:0]   m_a, m_b;
   logic          m_done;
   logic [17:0]   m_p;
   logic          eng_moved;

   function automatic logic [17:0] dot3(input logic [47:0] a, input logic [47:0] b);
      longint s;
      s = 0;
      for (int e = 0; e < 3; e++) begin
         s = s + longint'($signed(a[e*16 +: 16])) * longint'($signed(b[e*16 +: 16]));
      end
      s = s >>> 14;
      return s[17:0];
   endfunction

   always @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         m_active  <= 1'b0;
         m_cnt     <= 0;
         m_done    <= 1'b0;
         m_p       <= '0;
         m_a       <= '0;
         m_b       <= '0;
         eng_moved <= 1'b0;
      end else begin
         m_done <= 1'b0;
         if (eng_valid_in && !eng_hang) begin
            m_a      <= eng_A;
            m_b      <= eng_B;
            m_cnt    <= LAT;
            m_active <= 1'b1;
         end else if (m_active) begin
            if (eng_A != m_a || eng_B != m_b) eng_moved <= 1'b1;
            if (m_cnt == 1) begin
               m_done   <= 1'b1;
               m_p      <= dot3(eng_A, eng_B);
               m_active <= 1'b0;
            end
            m_cnt <= m_cnt - 1;
         end
      end
   end

   assign eng_valid_out = m_done | stray;
   assign eng_P         = m_p;

   // Observers for start pulses, watchdog wait length and req_ready legality
   int pulses = 0;
   int wait_cycles = 0;
   int ready_bad = 0;

   always @(posedge clk_in) if (eng_valid_in) pulses <= pulses + 1;

   always @(negedge clk_in) begin
      if (busy && !eng_valid_in && !resp_valid) wait_cycles <= wait_cycles + 1;
      if (req_ready != '0 && (busy || $countones(req_ready) != 1 || (req_ready & ~req_valid) != '0))
         ready_bad <= ready_bad + 1;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      @(negedge clk_in);
   endtask

   task automatic set_req(input int id, input logic [15:0] a0, input logic [15:0] a1,
                          input logic [15:0] a2, input logic [15:0] b0,
                          input logic [15:0] b1, input logic [15:0] b2);
      req_A[(id*3+0)*16 +: 16] = a0;
      req_A[(id*3+1)*16 +: 16] = a1;
      req_A[(id*3+2)*16 +: 16] = a2;
      req_B[(id*3+0)*16 +: 16] = b0;
      req_B[(id*3+1)*16 +: 16] = b1;
      req_B[(id*3+2)*16 +: 16] = b2;
   endtask

   task automatic wait_resp();
      for (int i = 0; i < 100; i++) begin
         if (resp_valid) break;
         @(negedge clk_in);
      end
      chk("resp_arrives", 64'(resp_valid), 64'd1);
   endtask

   task automatic accept();
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
   endtask

   int p0, w0;

   initial begin
      // Reset values, with requests present to show req_ready is gated
      req_valid = 3'b111;
      @(negedge clk_in);
      chk("rst_ready",   64'(req_ready), 64'd0);
      chk("rst_outputs", 64'({resp_valid, resp_err, eng_valid_in, busy}), 64'd0);
      chk("rst_data",    64'({resp_id, resp_P}), 64'd0);
      chk("rst_eng",     64'({eng_A, eng_B}), 64'd0);
      req_valid = '0;
      tick();
      rst_in = 1'b0;
      tick();

      // Single job from requester 0: 1.0*1.0 + 0.5*1.0 - 0.25*1.0 = 1.25
      set_req(0, 16'sd16384, 16'sd8192, -16'sd4096, 16'sd16384, 16'sd16384, 16'sd16384);
      req_valid = 3'b001;
      #1;
      chk("basic_ready", 64'(req_ready), 64'b001);
      p0 = pulses;
      tick();
      chk("basic_issue", 64'(eng_valid_in), 64'd1);
      chk("basic_engA",  64'(eng_A), 64'h0000_F000_2000_4000);
      req_valid = '0;
      wait_resp();
      chk("basic_id",    64'(resp_id), 64'd0);
      chk("basic_P",     64'(resp_P), 64'd20480);
      chk("basic_err",   64'(resp_err), 64'd0);
      chk("basic_pulse", 64'(pulses - p0), 64'd1);
      chk("basic_stable", 64'(eng_moved), 64'd0);
      accept();
      chk("basic_idle",  64'({resp_valid, busy}), 64'd0);

      // Held response: req1 = 0.5*1 - 0.5*1 + 0.5*1 = 0.5 -> 8192; req2 waits
      set_req(1, 16'sd8192, 16'sd8192, 16'sd8192, 16'sd16384, -16'sd16384, 16'sd16384);
      set_req(2, -16'sd16384, 16'sd4096, 16'sd0, 16'sd16384, 16'sd16384, 16'sd5);
      req_valid = 3'b110;
      #1;
      chk("hold_grant1", 64'(req_ready), 64'b010);
      tick();
      req_valid = 3'b100;
      wait_resp();
      for (int c = 0; c < 10; c++) begin
         chk("hold_stable", 64'({resp_valid, resp_id, resp_P, req_ready}),
             64'({1'b1, 2'd1, 18'd8192, 3'b000}));
         tick();
      end
      accept();
      #1;
      chk("hold_grant2", 64'(req_ready), 64'b100);
      tick();
      req_valid = '0;
      wait_resp();
      // -1.0 + 0.25 = -0.75 -> -12288 as 18-bit pattern 0x3D000
      chk("req2_id", 64'(resp_id), 64'd2);
      chk("req2_P",  64'(resp_P), 64'h3D000);
      accept();

      // All requesters held valid: service order 0,1,2,0
      set_req(0, 16'sd16384, 16'sd0, 16'sd0, 16'sd16384, 16'sd0, 16'sd0);
      set_req(1, 16'sd0, 16'sd16384, 16'sd0, 16'sd0, -16'sd8192, 16'sd0);
      set_req(2, 16'sd0, 16'sd0, 16'sd4096, 16'sd0, 16'sd0, 16'sd4096);
      req_valid = 3'b111;
      wait_resp();
      chk("rr_id0", 64'(resp_id), 64'd0);
      chk("rr_P0",  64'(resp_P), 64'd16384);
      accept();
      wait_resp();
      chk("rr_id1", 64'(resp_id), 64'd1);
      chk("rr_P1",  64'(resp_P), 64'h3E000);
      accept();
      wait_resp();
      chk("rr_id2", 64'(resp_id), 64'd2);
      chk("rr_P2",  64'(resp_P), 64'd1024);
      accept();
      wait_resp();
      chk("rr_id3", 64'(resp_id), 64'd0);
      accept();
      req_valid = '0;
      tick();

      // Hung engine: watchdog gives an error response after TIMEOUT wait cycles
      eng_hang = 1'b1;
      req_valid = 3'b001;
      tick();
      req_valid = '0;
      w0 = wait_cycles;
      wait_resp();
      chk("to_err",    64'(resp_err), 64'd1);
      chk("to_P",      64'(resp_P), 64'd0);
      chk("to_id",     64'(resp_id), 64'd0);
      chk("to_cycles", 64'(wait_cycles - w0), 64'd16);
      accept();
      eng_hang = 1'b0;
      stray = 1'b1;
      tick();
      stray = 1'b0;
      for (int c = 0; c < 3; c++) begin
         chk("stray_ignored", 64'({resp_valid, busy}), 64'd0);
         tick();
      end

      // Full negative scale: 3 * 1.0 * 2^16 -> 196608 pattern carried unchanged
      set_req(0, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000);
      req_valid = 3'b001;
      tick();
      req_valid = '0;
      wait_resp();
      chk("neg_P",   64'(resp_P), 64'd196608);
      chk("neg_err", 64'(resp_err), 64'd0);
      accept();

      // Reset in the middle of WAIT, then pointer restart favours requester 1 over 2
      set_req(1, 16'sd0, 16'sd16384, 16'sd0, 16'sd0, -16'sd8192, 16'sd0);
      set_req(2, 16'sd0, 16'sd0, 16'sd4096, 16'sd0, 16'sd0, 16'sd4096);
      eng_hang = 1'b1;
      req_valid = 3'b001;
      tick();
      req_valid = 3'b110;
      tick();
      tick();
      chk("mid_busy", 64'(busy), 64'd1);
      rst_in = 1'b1;
      #1;
      chk("mid_rst_out", 64'({busy, resp_valid, eng_valid_in, req_ready}), 64'd0);
      chk("mid_rst_eng", 64'({eng_A, eng_B, resp_P}), 64'd0);
      tick();
      rst_in = 1'b0;
      eng_hang = 1'b0;
      #1;
      chk("post_rst_grant", 64'(req_ready), 64'b010);
      tick();
      req_valid = 3'b100;
      wait_resp();
      chk("post_id1", 64'(resp_id), 64'd1);
      chk("post_P1",  64'(resp_P), 64'h3E000);
      accept();
      tick();
      req_valid = '0;
      wait_resp();
      chk("post_id2", 64'(resp_id), 64'd2);
      chk("post_P2",  64'(resp_P), 64'd1024);
      accept();

      chk("ready_onehot_idle", 64'(ready_bad), 64'd0);
      chk("eng_operands_stable", 64'(eng_moved), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
